// File: rtl/decode_exec_unit.sv
// decode_exec_unit: decode/execute slice of a single-cycle MIPS datapath.
// Main control decoder, 16->32 immediate extender, ALU operand selection and
// a 32-bit ALU. Every output is registered, giving one clock of latency.
module decode_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [4:0]       ctrl_alu,
    output logic [1:0]       ctrl_reg_dst,
    output logic [1:0]       ctrl_alu_src_a,
    output logic [1:0]       ctrl_alu_src_b,
    output logic [1:0]       ctrl_mem2reg,
    output logic             ctrl_ext,
    output logic             ctrl_reg_wr,
    output logic             ctrl_mem_wr,
    output logic [4:0]       wr_reg,
    output logic [WIDTH-1:0] imm_ext,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt_idx;
    logic [4:0] rd_idx;
    logic [4:0] shamt;

    assign op     = instr[31:26];
    assign funct  = instr[5:0];
    assign rt_idx = instr[20:16];
    assign rd_idx = instr[15:11];
    assign shamt  = instr[10:6];

    logic [4:0]       d_alu;
    logic [1:0]       d_reg_dst;
    logic [1:0]       d_src_a;
    logic [1:0]       d_src_b;
    logic [1:0]       d_mem2reg;
    logic             d_ext;
    logic             d_reg_wr;
    logic             d_mem_wr;
    logic             d_illegal;

    logic [WIDTH-1:0] d_imm;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] d_result;
    logic [4:0]       d_wr_reg;

    // Main control decoder: opcode/funct to control word
    always_comb begin
        d_alu     = ALU_ADD;
        d_reg_dst = 2'd0;
        d_src_a   = 2'd0;
        d_src_b   = 2'd0;
        d_mem2reg = 2'd0;
        d_ext     = 1'b0;
        d_reg_wr  = 1'b0;
        d_mem_wr  = 1'b0;
        d_illegal = 1'b0;
        case (op)
            6'h00: begin
                d_reg_dst = 2'd1;
                d_reg_wr  = 1'b1;
                case (funct)
                    6'h20, 6'h21: d_alu = ALU_ADD;
                    6'h22, 6'h23: d_alu = ALU_SUB;
                    6'h24:        d_alu = ALU_AND;
                    6'h25:        d_alu = ALU_OR;
                    6'h26:        d_alu = ALU_XOR;
                    6'h27:        d_alu = ALU_NOR;
                    6'h2A:        d_alu = ALU_SLT;
                    6'h2B:        d_alu = ALU_SLTU;
                    6'h00: begin d_alu = ALU_SLL; d_src_a = 2'd2; end
                    6'h02: begin d_alu = ALU_SRL; d_src_a = 2'd2; end
                    6'h03: begin d_alu = ALU_SRA; d_src_a = 2'd2; end
                    6'h04:        d_alu = ALU_SLL;
                    6'h06:        d_alu = ALU_SRL;
                    6'h07:        d_alu = ALU_SRA;
                    6'h08: begin d_alu = ALU_ADD; d_reg_wr = 1'b0; end
                    default: begin
                        // Unknown funct: drop the R-type defaults back to zero
                        d_illegal = 1'b1;
                        d_reg_dst = 2'd0;
                        d_reg_wr  = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09: begin d_src_b = 2'd1; d_ext = 1'b1; d_reg_wr = 1'b1; d_alu = ALU_ADD;  end
            6'h0A:        begin d_src_b = 2'd1; d_ext = 1'b1; d_reg_wr = 1'b1; d_alu = ALU_SLT;  end
            6'h0B:        begin d_src_b = 2'd1; d_ext = 1'b1; d_reg_wr = 1'b1; d_alu = ALU_SLTU; end
            6'h0C:        begin d_src_b = 2'd1; d_reg_wr = 1'b1; d_alu = ALU_AND; end
            6'h0D:        begin d_src_b = 2'd1; d_reg_wr = 1'b1; d_alu = ALU_OR;  end
            6'h0E:        begin d_src_b = 2'd1; d_reg_wr = 1'b1; d_alu = ALU_XOR; end
            6'h0F: begin
                // lui: shift the zero-extended immediate left by the constant 16
                d_src_a  = 2'd1;
                d_src_b  = 2'd1;
                d_reg_wr = 1'b1;
                d_alu    = ALU_SLL;
            end
            6'h23: begin
                d_src_b   = 2'd1;
                d_ext     = 1'b1;
                d_reg_wr  = 1'b1;
                d_mem2reg = 2'd1;
                d_alu     = ALU_ADD;
            end
            6'h2B: begin
                d_src_b  = 2'd1;
                d_ext    = 1'b1;
                d_mem_wr = 1'b1;
                d_alu    = ALU_ADD;
            end
            6'h04, 6'h05: begin
                d_ext = 1'b1;
                d_alu = ALU_SUB;
            end
            6'h02: ;
            6'h03: begin
                d_reg_dst = 2'd2;
                d_mem2reg = 2'd2;
                d_reg_wr  = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    // Immediate extension and ALU operand selection
    always_comb begin
        d_imm = d_ext ? {{(WIDTH-16){instr[15]}}, instr[15:0]}
                      : {{(WIDTH-16){1'b0}}, instr[15:0]};
        case (d_src_a)
            2'd0:    op_a = rs_data;
            2'd1:    op_a = WIDTH'(16);
            2'd2:    op_a = {{(WIDTH-5){1'b0}}, shamt};
            default: op_a = '0;
        endcase
        case (d_src_b)
            2'd0:    op_b = rt_data;
            2'd1:    op_b = d_imm;
            default: op_b = '0;
        endcase
    end

    // ALU: arithmetic wraps, shifts move B by A[4:0]
    always_comb begin
        case (d_alu)
            ALU_ADD:  d_result = op_a + op_b;
            ALU_SUB:  d_result = op_a - op_b;
            ALU_AND:  d_result = op_a & op_b;
            ALU_OR:   d_result = op_a | op_b;
            ALU_XOR:  d_result = op_a ^ op_b;
            ALU_NOR:  d_result = ~(op_a | op_b);
            ALU_SLT:  d_result = ($signed(op_a) < $signed(op_b)) ? WIDTH'(1) : '0;
            ALU_SLTU: d_result = (op_a < op_b) ? WIDTH'(1) : '0;
            ALU_SLL:  d_result = op_b << op_a[4:0];
            ALU_SRL:  d_result = op_b >> op_a[4:0];
            ALU_SRA:  d_result = WIDTH'($signed(op_b) >>> op_a[4:0]);
            default:  d_result = '0;
        endcase
    end

    // Destination register resolution
    always_comb begin
        case (d_reg_dst)
            2'd0:    d_wr_reg = rt_idx;
            2'd1:    d_wr_reg = rd_idx;
            2'd2:    d_wr_reg = 5'd31;
            default: d_wr_reg = 5'd0;
        endcase
    end

    // Output register stage with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_alu       <= '0;
            ctrl_reg_dst   <= '0;
            ctrl_alu_src_a <= '0;
            ctrl_alu_src_b <= '0;
            ctrl_mem2reg   <= '0;
            ctrl_ext       <= 1'b0;
            ctrl_reg_wr    <= 1'b0;
            ctrl_mem_wr    <= 1'b0;
            wr_reg         <= '0;
            imm_ext        <= '0;
            alu_result     <= '0;
            zero           <= 1'b0;
            illegal        <= 1'b0;
        end else begin
            ctrl_alu       <= d_alu;
            ctrl_reg_dst   <= d_reg_dst;
            ctrl_alu_src_a <= d_src_a;
            ctrl_alu_src_b <= d_src_b;
            ctrl_mem2reg   <= d_mem2reg;
            ctrl_ext       <= d_ext;
            ctrl_reg_wr    <= d_reg_wr;
            ctrl_mem_wr    <= d_mem_wr;
            wr_reg         <= d_wr_reg;
            imm_ext        <= d_imm;
            alu_result     <= d_result;
            zero           <= (d_result == '0);
            illegal        <= d_illegal;
        end
    end

endmodule

// File: tb/tb_decode_exec_unit.sv
// tb_decode_exec_unit: directed vectors for decode_exec_unit, checked every
// cycle against an instruction-level model plus hand-computed literals.
module tb_decode_exec_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  ctrl_alu;
    logic [1:0]  ctrl_reg_dst;
    logic [1:0]  ctrl_alu_src_a;
    logic [1:0]  ctrl_alu_src_b;
    logic [1:0]  ctrl_mem2reg;
    logic        ctrl_ext;
    logic        ctrl_reg_wr;
    logic        ctrl_mem_wr;
    logic [4:0]  wr_reg;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        zero;
    logic        illegal;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    decode_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .ctrl_alu(ctrl_alu), .ctrl_reg_dst(ctrl_reg_dst),
        .ctrl_alu_src_a(ctrl_alu_src_a), .ctrl_alu_src_b(ctrl_alu_src_b),
        .ctrl_mem2reg(ctrl_mem2reg), .ctrl_ext(ctrl_ext),
        .ctrl_reg_wr(ctrl_reg_wr), .ctrl_mem_wr(ctrl_mem_wr),
        .wr_reg(wr_reg), .imm_ext(imm_ext), .alu_result(alu_result),
        .zero(zero), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  alu;
        logic [1:0]  dst;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [1:0]  m2r;
        logic        ext;
        logic        rw;
        logic        mw;
        logic [4:0]  wreg;
        logic [31:0] imm;
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } out_t;

    // Instruction-level model: results straight from each instruction's meaning
    function automatic out_t model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        out_t o;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [31:0] s;
        logic [31:0] z;
        op  = i[31:26];
        fn  = i[5:0];
        imm = i[15:0];
        s   = {{16{imm[15]}}, imm};
        z   = {16'h0000, imm};
        o = '0;
        o.imm  = z;
        o.wreg = i[20:16];
        o.res  = a + b;
        case (op)
            6'h00: begin
                o.dst = 2'd1; o.rw = 1'b1; o.wreg = i[15:11];
                case (fn)
                    6'h20, 6'h21: begin o.alu = 5'd0; o.res = a + b; end
                    6'h22, 6'h23: begin o.alu = 5'd1; o.res = a - b; end
                    6'h24: begin o.alu = 5'd2; o.res = a & b; end
                    6'h25: begin o.alu = 5'd3; o.res = a | b; end
                    6'h26: begin o.alu = 5'd4; o.res = a ^ b; end
                    6'h27: begin o.alu = 5'd5; o.res = ~(a | b); end
                    6'h2A: begin o.alu = 5'd6; o.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
                    6'h2B: begin o.alu = 5'd7; o.res = (a < b) ? 32'd1 : 32'd0; end
                    6'h00: begin o.alu = 5'd8;  o.sa = 2'd2; o.res = b << i[10:6]; end
                    6'h02: begin o.alu = 5'd9;  o.sa = 2'd2; o.res = b >> i[10:6]; end
                    6'h03: begin o.alu = 5'd10; o.sa = 2'd2; o.res = 32'(int'(b) >>> i[10:6]); end
                    6'h04: begin o.alu = 5'd8;  o.res = b << a[4:0]; end
                    6'h06: begin o.alu = 5'd9;  o.res = b >> a[4:0]; end
                    6'h07: begin o.alu = 5'd10; o.res = 32'(int'(b) >>> a[4:0]); end
                    6'h08: o.rw = 1'b0;
                    default: begin o.ill = 1'b1; o.dst = 2'd0; o.rw = 1'b0; o.wreg = i[20:16]; end
                endcase
            end
            6'h08, 6'h09: begin o.sb = 2'd1; o.ext = 1'b1; o.imm = s; o.rw = 1'b1; o.res = a + s; end
            6'h0A: begin o.alu = 5'd6; o.sb = 2'd1; o.ext = 1'b1; o.imm = s; o.rw = 1'b1;
                         o.res = (int'(a) < int'(s)) ? 32'd1 : 32'd0; end
            6'h0B: begin o.alu = 5'd7; o.sb = 2'd1; o.ext = 1'b1; o.imm = s; o.rw = 1'b1;
                         o.res = (a < s) ? 32'd1 : 32'd0; end
            6'h0C: begin o.alu = 5'd2; o.sb = 2'd1; o.rw = 1'b1; o.res = a & z; end
            6'h0D: begin o.alu = 5'd3; o.sb = 2'd1; o.rw = 1'b1; o.res = a | z; end
            6'h0E: begin o.alu = 5'd4; o.sb = 2'd1; o.rw = 1'b1; o.res = a ^ z; end
            6'h0F: begin o.alu = 5'd8; o.sa = 2'd1; o.sb = 2'd1; o.rw = 1'b1; o.res = {imm, 16'h0000}; end
            6'h23: begin o.sb = 2'd1; o.ext = 1'b1; o.imm = s; o.rw = 1'b1; o.m2r = 2'd1; o.res = a + s; end
            6'h2B: begin o.sb = 2'd1; o.ext = 1'b1; o.imm = s; o.mw = 1'b1; o.res = a + s; end
            6'h04, 6'h05: begin o.alu = 5'd1; o.ext = 1'b1; o.imm = s; o.res = a - b; end
            6'h02: ;
            6'h03: begin o.dst = 2'd2; o.m2r = 2'd2; o.rw = 1'b1; o.wreg = 5'd31; end
            default: o.ill = 1'b1;
        endcase
        o.zero = (o.res == 32'd0);
        return o;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model's own register stage: expected outputs one clock behind the inputs
    out_t exp_o;
    always @(posedge clk or negedge rst) begin
        if (!rst) exp_o <= '0;
        else      exp_o <= model(instr, rs_data, rt_data);
    end

    // Compare every field on each falling edge once checking is enabled
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("alu",     32'(ctrl_alu),       32'(exp_o.alu));
            cmp("reg_dst", 32'(ctrl_reg_dst),   32'(exp_o.dst));
            cmp("src_a",   32'(ctrl_alu_src_a), 32'(exp_o.sa));
            cmp("src_b",   32'(ctrl_alu_src_b), 32'(exp_o.sb));
            cmp("mem2reg", 32'(ctrl_mem2reg),   32'(exp_o.m2r));
            cmp("ext",     32'(ctrl_ext),       32'(exp_o.ext));
            cmp("reg_wr",  32'(ctrl_reg_wr),    32'(exp_o.rw));
            cmp("mem_wr",  32'(ctrl_mem_wr),    32'(exp_o.mw));
            cmp("wr_reg",  32'(wr_reg),         32'(exp_o.wreg));
            cmp("imm_ext", imm_ext,             exp_o.imm);
            cmp("result",  alu_result,          exp_o.res);
            cmp("zero",    32'(zero),           32'(exp_o.zero));
            cmp("illegal", 32'(illegal),        32'(exp_o.ill));
        end
    end

    task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        instr   = i;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
    endtask

    // Extra directed vectors checked by the model only
    logic [31:0] vec_i [16] = '{
        32'h00221822, 32'h00221824, 32'h00221825, 32'h00221826,
        32'h00221827, 32'h00021A02, 32'h00021940, 32'h00221804,
        32'h00221806, 32'h00221807, 32'h00200008, 32'h3825F0F0,
        32'h2825FFFF, 32'h8C22FFFC, 32'h14220004, 32'h0022183F
    };
    logic [31:0] vec_a [16] = '{
        32'h00000003, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFF0000,
        32'h00000000, 32'h0, 32'h0, 32'h00000024,
        32'h00000004, 32'h0000001F, 32'h00400000, 32'h12345678,
        32'hFFFFFFFE, 32'h00001000, 32'h00000009, 32'h1
    };
    logic [31:0] vec_b [16] = '{
        32'h00000005, 32'hFF00FF00, 32'h000000F0, 32'h0F0F0F0F,
        32'h00000000, 32'h80000001, 32'h00000003, 32'h00000001,
        32'h80000000, 32'h80000000, 32'h7, 32'h0,
        32'h0, 32'h0, 32'h00000009, 32'h2
    };

    initial begin
        rst = 1'b0;
        instr = '0;
        rs_data = '0;
        rt_data = '0;
        repeat (2) @(negedge clk);
        cmp("reset_result", alu_result, 32'h0);
        cmp("reset_reg_wr", 32'(ctrl_reg_wr), 32'h0);
        chk_en = 1'b1;
        rst = 1'b1;

        // add $3,$1,$2
        apply(32'h00221820, 32'd5, 32'd7);
        cmp("add_result", alu_result, 32'd12);
        cmp("add_wr_reg", 32'(wr_reg), 32'd3);

        // Asynchronous clear mid-cycle with nonzero outputs
        #2;
        rst = 1'b0;
        #1;
        cmp("async_result", alu_result, 32'h0);
        cmp("async_wr_reg", 32'(wr_reg), 32'h0);
        cmp("async_reg_wr", 32'(ctrl_reg_wr), 32'h0);
        cmp("async_imm",    imm_ext, 32'h0);
        cmp("async_alu",    32'(ctrl_alu), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        apply(32'h00221820, 32'd5, 32'd7);
        cmp("add2_result", alu_result, 32'd12);
        cmp("add2_wr_reg", 32'(wr_reg), 32'd3);
        cmp("add2_reg_wr", 32'(ctrl_reg_wr), 32'd1);
        cmp("add2_zero",   32'(zero), 32'd0);

        // lui $4,0x1234
        apply(32'h3C041234, 32'hDEADBEEF, 32'h0);
        cmp("lui_result", alu_result, 32'h12340000);
        cmp("lui_src_a",  32'(ctrl_alu_src_a), 32'd1);
        cmp("lui_ext",    32'(ctrl_ext), 32'd0);
        cmp("lui_wr_reg", 32'(wr_reg), 32'd4);

        // addi $5,$1,-1 with rs=1
        apply(32'h2025FFFF, 32'd1, 32'h0);
        cmp("addi_imm",    imm_ext, 32'hFFFFFFFF);
        cmp("addi_result", alu_result, 32'h0);
        cmp("addi_zero",   32'(zero), 32'd1);

        // ori $5,$1,0xFFFF
        apply(32'h3425FFFF, 32'd1, 32'h0);
        cmp("ori_imm",    imm_ext, 32'h0000FFFF);
        cmp("ori_result", alu_result, 32'h0000FFFF);

        // slt / sltu with rs=-1, rt=1
        apply(32'h0022182A, 32'hFFFFFFFF, 32'd1);
        cmp("slt_result", alu_result, 32'd1);
        apply(32'h0022182B, 32'hFFFFFFFF, 32'd1);
        cmp("sltu_result", alu_result, 32'd0);

        // sra $3,$2,4
        apply(32'h00021903, 32'h0, 32'h80000000);
        cmp("sra_result", alu_result, 32'hF8000000);

        // sw $2,8($1)
        apply(32'hAC220008, 32'h10, 32'h0BADF00D);
        cmp("sw_mem_wr", 32'(ctrl_mem_wr), 32'd1);
        cmp("sw_reg_wr", 32'(ctrl_reg_wr), 32'd0);
        cmp("sw_result", alu_result, 32'h18);

        // beq $1,$2 with equal operands
        apply(32'h10220010, 32'h55, 32'h55);
        cmp("beq_zero",   32'(zero), 32'd1);
        cmp("beq_reg_wr", 32'(ctrl_reg_wr), 32'd0);

        // jal
        apply(32'h0C000010, 32'h1, 32'h2);
        cmp("jal_wr_reg",  32'(wr_reg), 32'd31);
        cmp("jal_mem2reg", 32'(ctrl_mem2reg), 32'd2);

        // op 0x3F
        apply(32'hFC000000, 32'h3, 32'h4);
        cmp("ill_flag",   32'(illegal), 32'd1);
        cmp("ill_reg_wr", 32'(ctrl_reg_wr), 32'd0);
        cmp("ill_mem_wr", 32'(ctrl_mem_wr), 32'd0);

        // j
        apply(32'h08000040, 32'h3, 32'h4);
        cmp("j_reg_wr", 32'(ctrl_reg_wr), 32'd0);

        for (int k = 0; k < 16; k++) begin
            apply(vec_i[k], vec_a[k], vec_b[k]);
        end
        cmp("ill_funct_flag", 32'(illegal), 32'd1);

        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_exec_unit.md
Name: decode_exec_unit

Overview:
- Decode/execute slice of the single-cycle MIPS datapath: main control decoder, 16→32 immediate extender, ALU operand selection and 32-bit ALU in one block.
- Takes the fetched instruction and the two register-file read values; produces the control word, extended immediate, write-register index, ALU result and zero flag.
- All outputs are registered, with one clock of latency, so a downstream writeback/memory stage samples a stable execute result.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- instr  in  32  instruction word
- rs_data  in  32  register-file read port 1 (instr[25:21])
- rt_data  in  32  register-file read port 2 (instr[20:16])
- ctrl_alu  out  5  ALU opcode
- ctrl_reg_dst  out  2  0=rt, 1=rd, 2=$31
- ctrl_alu_src_a  out  2  0=rs_data, 1=constant 16, 2=shamt zero-extended
- ctrl_alu_src_b  out  2  0=rt_data, 1=extended immediate
- ctrl_mem2reg  out  2  0=ALU, 1=memory, 2=PC+4
- ctrl_ext  out  1  1=sign-extend, 0=zero-extend
- ctrl_reg_wr  out  1  register write enable
- ctrl_mem_wr  out  1  data-memory write enable
- wr_reg  out  5  resolved destination register index
- imm_ext  out  32  extended immediate
- alu_result  out  32  ALU result
- zero  out  1  alu_result == 0
- illegal  out  1  unrecognised opcode/funct

Behaviour:
- Combinational path: decode(instr) → ext → operand muxes → ALU. All outputs are captured on the rising edge of clk.
- rst low forces every output to 0 immediately, regardless of clk. The first capture happens on the first rising edge after rst goes high.
- Ext: imm_ext = ctrl_ext ? {{16{instr[15]}}, instr[15:0]} : {16'b0, instr[15:0]}.
- ALU opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed, result 0/1), 7 SLTU (unsigned, result 0/1)
  - 8 SLL, 9 SRL, 10 SRA: shift B by A[4:0]
  - 11–31: result 0
- Arithmetic wraps modulo 2^32; overflow never traps.
- Decoding, R-type (op 0; reg_dst=1, reg_wr=1, src_a=0, src_b=0, mem2reg=0 unless stated):
  - funct 20/21 ADD; 22/23 SUB; 24 AND; 25 OR; 26 XOR; 27 NOR; 2A SLT; 2B SLTU
  - funct 00/02/03: SLL/SRL/SRA with src_a=2
  - funct 04/06/07: SLL/SRL/SRA with src_a=0
  - funct 08 (jr): reg_wr=0, alu=ADD
- Decoding, I-type (reg_dst=0, src_a=0, src_b=1):
  - 08/09 ADD sext; 0A SLT sext; 0B SLTU sext
  - 0C AND zext; 0D OR zext; 0E XOR zext
  - 0F lui: src_a=1, SLL, zext
  - All of the above: reg_wr=1.
  - 23 lw: ADD sext, reg_wr=1, mem2reg=1
  - 2B sw: ADD sext, mem_wr=1, reg_wr=0
  - 04/05 beq/bne: src_b=0, SUB, sext, reg_wr=0
  - 02 j: all-zero control
  - 03 jal: reg_dst=2, mem2reg=2, reg_wr=1
- wr_reg is rt, rd or 31 according to ctrl_reg_dst.
- Any other op/funct: illegal=1, all write enables 0, other controls 0. The ALU still evaluates with opcode 0.
- Writes to register 0 are not suppressed here; suppression is the register file's job.

Test Plan:
- rst low mid-operation with nonzero outputs → all outputs 0 immediately (asynchronous). Release rst, apply add $3,$1,$2 with rs=5, rt=7 → next edge: alu_result=12, wr_reg=3, reg_wr=1, zero=0.
- lui $4,0x1234 → alu_result=0x12340000, src_a=1, ext=0, wr_reg=4.
- addi with imm 0xFFFF and rs=1 → imm_ext=0xFFFFFFFF, alu_result=0, zero=1. ori with the same imm → imm_ext=0x0000FFFF.
- slt vs sltu with rs=0xFFFFFFFF, rt=1 → 1 and 0 respectively. sra by 4 of 0x80000000 → 0xF8000000.
- sw offset 8, rs=0x10 → mem_wr=1, reg_wr=0, alu_result=0x18. beq with rs=rt → zero=1, reg_wr=0.
- jal → wr_reg=31, mem2reg=2. op=0x3F → illegal=1, reg_wr=0, mem_wr=0.
